// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the video RAM arbiter.
// Owner encodings name the requester driving a RAM port in a given cycle.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_VIDEO  = 2'd1,
    OWN_CPU    = 2'd2,
    OWN_LOADER = 2'd3
  } owner_e;

  localparam int MAXWAIT_DEF = 4;
  localparam int CWAIT_W     = 4;

endpackage

// File: rtl/vram_arb_arb_rr2.sv
// Two-way round-robin arbiter with a combinational grant.
// When both requesters ask, the one not served last wins; wlast_r=1 means req[1] went last.
module arb_rr2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic wlast_r;

  // grant selection; a tie goes to the side not served last
  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      gnt = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = wlast_r ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // remember who was served last; reset favours req[0] on the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      wlast_r <= 1'b1;
    end else if (adv && (gnt != 2'b00)) begin
      wlast_r <= gnt[1];
    end
  end

endmodule

// File: rtl/vram_arb.sv
// Arbiter sharing one dual-port video RAM between video fetch, CPU and loader.
// Read port: video > CPU with a starvation guard; write port: CPU/loader round-robin.
module vram_arb
  import vram_arb_pkg::*;
#(
  parameter  int KB      = 16,
  parameter  int MAXWAIT = MAXWAIT_DEF,
  localparam int AW      = $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vreq,
  input  logic [AW-1:0] va,
  output logic          vack,
  output logic          vvalid,
  output logic [7:0]    vq,
  input  logic          creq,
  input  logic          cwe,
  input  logic [AW-1:0] ca,
  input  logic [7:0]    cd,
  output logic          cack,
  output logic          cvalid,
  output logic [7:0]    cq,
  input  logic          lreq,
  input  logic [AW-1:0] la,
  input  logic [7:0]    ld,
  output logic          lack,
  output logic          ce1,
  output logic [AW-1:0] a1,
  input  logic [7:0]    q1,
  output logic          ce2,
  output logic          we2,
  output logic [7:0]    d2,
  output logic [AW-1:0] a2
);

  localparam logic [CWAIT_W-1:0] MAXW = CWAIT_W'(MAXWAIT);

  logic               cpu_rd_s;
  logic               cpu_wr_s;
  logic               starve_s;
  logic               cack_rd_s;
  owner_e             rd_own_s;
  logic [CWAIT_W-1:0] cwait_r;
  logic [AW-1:0]      a1_r;
  logic [AW-1:0]      a2_r;
  logic [7:0]         d2_r;
  logic               vvalid_r;
  logic               cvalid_r;
  logic [1:0]         wreq_s;
  logic [1:0]         wgnt_s;

  assign cpu_rd_s = creq & ~cwe;
  assign cpu_wr_s = creq & cwe;
  assign starve_s = cpu_rd_s & (cwait_r == MAXW);

  // read-port owner: a starved CPU read overrides video for one cycle
  always_comb begin
    rd_own_s = OWN_NONE;
    if (reset) begin
      rd_own_s = OWN_NONE;
    end else if (starve_s) begin
      rd_own_s = OWN_CPU;
    end else if (vreq) begin
      rd_own_s = OWN_VIDEO;
    end else if (cpu_rd_s) begin
      rd_own_s = OWN_CPU;
    end else begin
      rd_own_s = OWN_NONE;
    end
  end

  // read-port drive; the address holds its last value while idle
  always_comb begin
    vack      = 1'b0;
    cack_rd_s = 1'b0;
    ce1       = 1'b0;
    a1        = reset ? {AW{1'b0}} : a1_r;
    case (rd_own_s)
      OWN_VIDEO: begin
        vack = 1'b1;
        ce1  = 1'b1;
        a1   = va;
      end
      OWN_CPU: begin
        cack_rd_s = 1'b1;
        ce1       = 1'b1;
        a1        = ca;
      end
      default: begin
        ce1 = 1'b0;
      end
    endcase
  end

  // starvation counter: counts denied cycles of a pending CPU read
  always_ff @(posedge clock) begin
    if (reset) begin
      cwait_r <= {CWAIT_W{1'b0}};
    end else if (!cpu_rd_s || cack_rd_s) begin
      cwait_r <= {CWAIT_W{1'b0}};
    end else if (cwait_r != MAXW) begin
      cwait_r <= cwait_r + {{(CWAIT_W-1){1'b0}}, 1'b1};
    end
  end

  // held addresses/data and one-cycle read-valid pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      a1_r     <= {AW{1'b0}};
      a2_r     <= {AW{1'b0}};
      d2_r     <= 8'h00;
      vvalid_r <= 1'b0;
      cvalid_r <= 1'b0;
    end else begin
      a1_r     <= a1;
      a2_r     <= a2;
      d2_r     <= d2;
      vvalid_r <= vack;
      cvalid_r <= cack_rd_s;
    end
  end

  // a grant just before reset must not surface as a valid pulse during reset
  assign vvalid = vvalid_r & ~reset;
  assign cvalid = cvalid_r & ~reset;
  assign vq     = q1;
  assign cq     = q1;

  assign wreq_s = {lreq, cpu_wr_s};

  arb_rr2 u_wr_arb (
    .clock (clock),
    .reset (reset),
    .req   (wreq_s),
    .adv   (1'b1),
    .gnt   (wgnt_s)
  );

  // write-port drive from the round-robin winner
  always_comb begin
    ce2 = 1'b0;
    we2 = 1'b1;
    a2  = reset ? {AW{1'b0}} : a2_r;
    d2  = reset ? 8'h00 : d2_r;
    case (wgnt_s)
      2'b01: begin
        ce2 = 1'b1;
        we2 = 1'b0;
        a2  = ca;
        d2  = cd;
      end
      2'b10: begin
        ce2 = 1'b1;
        we2 = 1'b0;
        a2  = la;
        d2  = ld;
      end
      default: begin
        ce2 = 1'b0;
      end
    endcase
  end

  assign cack = cack_rd_s | wgnt_s[0];
  assign lack = wgnt_s[1];

endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: directed scenarios then random traffic,
// checked every cycle against a behavioural model of the arbitration rules and RAM.
module tb_vram_arb;

  localparam int AW = 14;
  localparam int MW = 4;
  localparam int NW = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          vreq, creq, cwe, lreq;
  logic [AW-1:0] va, ca, la;
  logic [7:0]    cd, ld;
  logic          vack, vvalid, cack, cvalid, lack;
  logic [7:0]    vq, cq, q1, d2;
  logic          ce1, ce2, we2;
  logic [AW-1:0] a1, a2;

  always #5 clock = ~clock;

  vram_arb #(.KB(16), .MAXWAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .vreq(vreq), .va(va), .vack(vack), .vvalid(vvalid), .vq(vq),
    .creq(creq), .cwe(cwe), .ca(ca), .cd(cd), .cack(cack), .cvalid(cvalid), .cq(cq),
    .lreq(lreq), .la(la), .ld(ld), .lack(lack),
    .ce1(ce1), .a1(a1), .q1(q1),
    .ce2(ce2), .we2(we2), .d2(d2), .a2(a2)
  );

  // Bench-side dual-port RAM (read-before-write), plus a preload port
  logic [7:0]    mem [0:NW-1];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [7:0]    pre_d;

  always @(posedge clock) begin
    if (ce1) q1 <= mem[a1];
    if (ce2 && !we2) mem[a2] <= d2;
    else if (pre_we) mem[pre_a] <= pre_d;
  end

  // Reference model state
  logic [7:0]    ref_mem [0:NW-1];
  int            streak;
  bit            last_ldr;
  logic [AW-1:0] m_a1, m_a2;
  logic [7:0]    m_d2;
  bit            xv_valid, xc_valid;
  logic [7:0]    xv_q, xc_q;
  bit            ev, ec, ecr, ecw, el;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict and compare at negedge, advance the model at posedge.
  task automatic step();
    bit            crd, cwr;
    logic [AW-1:0] ea1, ea2;
    logic [7:0]    ed2;
    @(negedge clock);
    crd = creq && !cwe;
    cwr = creq && cwe;
    ev = 1'b0; ecr = 1'b0; ecw = 1'b0; el = 1'b0;
    if (!reset) begin
      ecr = crd && (!vreq || streak >= MW);
      ev  = vreq && !ecr;
      if (cwr && lreq) begin
        ecw = last_ldr;
        el  = !last_ldr;
      end else begin
        ecw = cwr;
        el  = lreq;
      end
    end
    ec  = ecr || ecw;
    ea1 = reset ? {AW{1'b0}} : ev ? va : ecr ? ca : m_a1;
    ea2 = reset ? {AW{1'b0}} : ecw ? ca : el ? la : m_a2;
    ed2 = reset ? 8'h00 : ecw ? cd : el ? ld : m_d2;
    chk("vack", vack, ev);
    chk("cack", cack, ec);
    chk("lack", lack, el);
    chk("ce1", ce1, ev || ecr);
    chk("a1", a1, ea1);
    chk("ce2", ce2, ecw || el);
    chk("we2", we2, !(ecw || el));
    chk("a2", a2, ea2);
    chk("d2", d2, ed2);
    chk("vvalid", vvalid, xv_valid && !reset);
    chk("cvalid", cvalid, xc_valid && !reset);
    if (xv_valid && !reset) chk("vq", vq, xv_q);
    if (xc_valid && !reset) chk("cq", cq, xc_q);
    @(posedge clock);
    xv_valid = ev;
    xv_q     = ref_mem[va];
    xc_valid = ecr;
    xc_q     = ref_mem[ca];
    if (ecw) ref_mem[ca] = cd;
    if (el)  ref_mem[la] = ld;
    if (reset) streak = 0;
    else if (crd && !ecr) streak = (streak + 1 > MW) ? MW : streak + 1;
    else streak = 0;
    if (reset) last_ldr = 1'b1;
    else if (ecw || el) last_ldr = el;
    m_a1 = ea1;
    m_a2 = ea2;
    m_d2 = ed2;
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    ref_mem[a] = d;
    step();
    pre_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pre_we = 1'b0; pre_a = {AW{1'b0}}; pre_d = 8'h00;
    vreq = 1'b1; va = 14'd5; creq = 1'b1; cwe = 1'b0; ca = 14'd6; cd = 8'h00;
    lreq = 1'b1; la = 14'd7; ld = 8'h3C;
    streak = 0; last_ldr = 1'b1; xv_valid = 1'b0; xc_valid = 1'b0;
    m_a1 = {AW{1'b0}}; m_a2 = {AW{1'b0}}; m_d2 = 8'h00;
    xv_q = 8'h00; xc_q = 8'h00;
    @(posedge clock); #1;

    // 1: reset held with all requests, then release
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("t1_vack", vack, 1'b1);
    chk("t1_lack", lack, 1'b1);
    chk("t1_cack", cack, 1'b0);
    step();
    vreq = 1'b0; lreq = 1'b0;
    #1;
    chk("t1_vvalid", vvalid, 1'b1);
    step();
    creq = 1'b0;
    step();

    poke(14'h1234, 8'hA5);
    poke(14'h0100, 8'h11);
    for (int i = 0; i < 64; i++) poke(AW'(i), 8'($urandom));

    // 2: single CPU read
    creq = 1'b1; cwe = 1'b0; ca = 14'h1234;
    step();
    creq = 1'b0;
    #1;
    chk("t2_cvalid", cvalid, 1'b1);
    chk("t2_cq", cq, 8'hA5);
    chk("t2_vvalid", vvalid, 1'b0);
    step();

    // 3: starvation guard with video held continuously
    vreq = 1'b1; va = 14'd3; creq = 1'b1; cwe = 1'b0; ca = 14'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t3_vack%0d", i), vack, (i < 4) ? 1'b1 : 1'b0);
      chk($sformatf("t3_cack%0d", i), cack, (i == 4) ? 1'b1 : 1'b0);
      step();
    end
    creq = 1'b0;
    #1;
    chk("t3_vack_resume", vack, 1'b1);
    step();
    vreq = 1'b0;
    step();

    // 4: CPU and loader writes contending
    creq = 1'b1; cwe = 1'b1; ca = 14'h40; cd = 8'($urandom);
    lreq = 1'b1; la = 14'h30; ld = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t4_cack%0d", i), cack, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("t4_lack%0d", i), lack, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("t4_we2_%0d", i), we2, 1'b0);
      step();
      if (i % 2 == 0) begin ca = ca + 14'd1; cd = 8'($urandom); end
      else begin la = la + 14'd1; ld = 8'($urandom); end
    end
    creq = 1'b0; lreq = 1'b0;
    step();

    // 5: read and write of the same address in one cycle
    creq = 1'b1; cwe = 1'b0; ca = 14'h0100;
    lreq = 1'b1; la = 14'h0100; ld = 8'h22;
    step();
    creq = 1'b0; lreq = 1'b0;
    #1;
    chk("t5_cq_old", cq, 8'h11);
    creq = 1'b1;
    step();
    creq = 1'b0;
    #1;
    chk("t5_cq_new", cq, 8'h22);
    step();

    // 6: reset right after a video grant
    vreq = 1'b1; va = 14'd9;
    step();
    reset = 1'b1;
    #1;
    chk("t6_vvalid_rst", vvalid, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("t6_vack", vack, 1'b1);
    step();
    vreq = 1'b0;
    #1;
    chk("t6_vvalid", vvalid, 1'b1);
    step();

    // Random traffic; requesters hold until served
    for (int n = 0; n < 600; n++) begin
      if (!vreq || ev) begin
        vreq = ($urandom_range(0, 3) != 0);
        va   = AW'($urandom_range(0, 63));
      end
      if (!creq || ec) begin
        creq = ($urandom_range(0, 2) != 0);
        cwe  = $urandom_range(0, 1);
        ca   = AW'($urandom_range(0, 63));
        cd   = 8'($urandom);
      end
      if (!lreq || el) begin
        lreq = ($urandom_range(0, 1) != 0);
        la   = AW'($urandom_range(0, 63));
        ld   = 8'($urandom);
      end
      step();
    end
    vreq = 1'b0; creq = 1'b0; lreq = 1'b0;
    step();

    for (int i = 0; i < 64; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);
    chk("mem_1234", mem[14'h1234], ref_mem[14'h1234]);
    chk("mem_0100", mem[14'h0100], 8'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
